// File: rtl/led_fx_pkg.sv
// Shared definitions for the LED bar effects: FSM state codes, shift direction
// constants and the default timing shared with the shifter top level.
package led_fx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } led_state_e;

  localparam logic DIR_R2L = 1'b1;
  localparam logic DIR_L2R = 1'b0;

  localparam int unsigned DEF_TICK_DIV   = 25_000_000;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_HOLD_STEPS = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while en is high and flags the last count with
// a one-cycle tick; the count is held at zero while en is low.
module led_tick_gen
  import led_fx_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/led_fill_seq.sv
// Fill/drain step sequencer feeding the serial LED shifter (s_in, lr, shift_en).
// Define LED_FX_HOLD_EN to insert HOLD_STEPS idle ticks at full and at empty.
module led_fill_seq
  import led_fx_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HOLD_STEPS = DEF_HOLD_STEPS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       dir_sw,
  output logic                       s_in,
  output logic                       lr,
  output logic                       shift_en,
  output logic [1:0]                 phase,
  output logic [$clog2(WIDTH+1)-1:0] step_cnt
);

  localparam int unsigned SW    = $clog2(WIDTH + 1);
  localparam int unsigned MAXC  = (HOLD_STEPS > WIDTH) ? HOLD_STEPS : WIDTH;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);
`ifdef LED_FX_HOLD_EN
  localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(HOLD_STEPS);
`endif

  led_state_e       state_q, state_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             s_in_q, s_in_d;
  logic             lr_q, lr_d;
  logic             shift_en_q, shift_en_d;
  logic             tick;
  logic             tick_en;

  // Prescaler stops and clears in the same edge that run drops.
  assign tick_en = run && (state_q != ST_IDLE);

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .tick (tick)
  );

  // A phase ends one cycle after its last strobe, so s_in never changes under a strobe.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    s_in_d     = s_in_q;
    lr_d       = lr_q;
    shift_en_d = 1'b0;
    if (!run) begin
      state_d    = ST_IDLE;
      step_cnt_d = '0;
      s_in_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_FILL;
          step_cnt_d = '0;
          s_in_d     = 1'b1;
          lr_d       = dir_sw ? DIR_R2L : DIR_L2R;
        end
        ST_FILL: begin
          if (step_cnt_q == LAST_STEP) begin
            step_cnt_d = '0;
`ifdef LED_FX_HOLD_EN
            state_d    = ST_HOLD;
`else
            state_d    = ST_DRAIN;
            s_in_d     = 1'b0;
`endif
          end else if (tick) begin
            shift_en_d = 1'b1;
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (step_cnt_q == LAST_STEP) begin
            step_cnt_d = '0;
`ifdef LED_FX_HOLD_EN
            state_d    = ST_HOLD;
`else
            state_d    = ST_FILL;
            s_in_d     = 1'b1;
            lr_d       = dir_sw ? DIR_R2L : DIR_L2R;
`endif
          end else if (tick) begin
            shift_en_d = 1'b1;
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
`ifdef LED_FX_HOLD_EN
          // s_in still carries the previous phase, which tells us where to go next.
          if (step_cnt_q == LAST_HOLD) begin
            step_cnt_d = '0;
            if (s_in_q) begin
              state_d = ST_DRAIN;
              s_in_d  = 1'b0;
            end else begin
              state_d = ST_FILL;
              s_in_d  = 1'b1;
              lr_d    = dir_sw ? DIR_R2L : DIR_L2R;
            end
          end else if (tick) begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
`else
          state_d    = ST_IDLE;
          step_cnt_d = '0;
          s_in_d     = 1'b0;
`endif
        end
        default: begin
          state_d    = ST_IDLE;
          step_cnt_d = '0;
          s_in_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      s_in_q     <= 1'b0;
      lr_q       <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      s_in_q     <= s_in_d;
      lr_q       <= lr_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign s_in     = s_in_q;
  assign lr       = lr_q;
  assign shift_en = shift_en_q;
  assign phase    = state_q;
  assign step_cnt = step_cnt_q[SW-1:0];

endmodule

// File: tb/tb_led_fill_seq.sv
// Testbench for led_fill_seq: a time-based model predicts every output each cycle,
// and a shifter fed by the DUT outputs checks the resulting LED patterns.
module tb_led_fill_seq;

  localparam int T = 4;
  localparam int W = 8;
`ifdef LED_FX_HOLD_EN
  localparam int H = 2;
`else
  localparam int H = 0;
`endif
  localparam int SEGS = 2 * (W + H);

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       dir_sw;
  logic       s_in;
  logic       lr;
  logic       shift_en;
  logic [1:0] phase;
  logic [3:0] step_cnt;

  int         pass_count = 0;
  int         check_count = 0;
  bit         m_running = 1'b0;
  int         m_t = 0;
  logic       m_lr = 1'b0;
  logic [7:0] dut_leds = 8'h00;
  int         m_hold_cycles = 0;
  int         obs_hold_cycles = 0;

  led_fill_seq #(
    .TICK_DIV  (T),
    .WIDTH     (W),
    .HOLD_STEPS(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .dir_sw  (dir_sw),
    .s_in    (s_in),
    .lr      (lr),
    .shift_en(shift_en),
    .phase   (phase),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs t cycles after the FILL entry edge: ticks land every T cycles,
  // and a phase boundary falls one cycle after the tick that completes the phase.
  function automatic void model_outputs(input bit running, input int t, output int ph,
                                        output int step, output bit sin, output bit en);
    int u, g, m;
    ph = 0; step = 0; sin = 1'b0; en = 1'b0;
    if (running) begin
      if (t == 0) begin
        ph = 1; sin = 1'b1;
      end else begin
        u = (t - 1) / T;
        g = u % SEGS;
        m = t / T - (u - g);
        if (g < W) begin
          ph = 1; step = m; sin = 1'b1;
        end else if (g < W + H) begin
          ph = 3; step = m - W; sin = 1'b1;
        end else if (g < 2 * W + H) begin
          ph = 2; step = m - W - H; sin = 1'b0;
        end else begin
          ph = 3; step = m - 2 * W - H; sin = 1'b0;
        end
        en = (t % T == 0) && (ph == 1 || ph == 2);
      end
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance n clock cycles, updating the model at each edge and checking at the falling edge.
  task automatic apply_stimulus(input int n);
    int ph0, ph1, st;
    bit si, en;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset) begin
        m_running = 1'b0;
        m_lr = 1'b0;
      end else if (!run) begin
        m_running = 1'b0;
      end else if (!m_running) begin
        m_running = 1'b1;
        m_t = 0;
        m_lr = dir_sw;
      end else begin
        model_outputs(1'b1, m_t, ph0, st, si, en);
        m_t++;
        model_outputs(1'b1, m_t, ph1, st, si, en);
        if (ph1 == 1 && ph0 != 1) m_lr = dir_sw;
      end
      @(negedge clk);
      model_outputs(m_running, m_t, ph0, st, si, en);
      check_output("phase", 32'(phase), 32'(ph0));
      check_output("step_cnt", 32'(step_cnt), 32'(st));
      check_output("s_in", 32'(s_in), 32'(si));
      check_output("lr", 32'(lr), 32'(m_lr));
      check_output("shift_en", 32'(shift_en), 32'(en));
      if (ph0 == 3) m_hold_cycles++;
      if (phase == 2'd3) obs_hold_cycles++;
      if (shift_en === 1'b1) dut_leds = lr ? {s_in, dut_leds[7:1]} : {dut_leds[6:0], s_in};
    end
  endtask

  initial begin
    int strobes, prev_cyc;
    logic prev_en;
    reset = 1'b1; run = 1'b0; dir_sw = 1'b0;
    apply_stimulus(2);
    reset = 1'b0;
    dut_leds = 8'h00;
    apply_stimulus(2);

    // Basic right-to-left fill and drain.
    dir_sw = 1'b1; run = 1'b1;
    apply_stimulus(1);
    apply_stimulus(T - 1);
    check_output("no_early_strobe", 32'(shift_en), 32'd0);
    apply_stimulus(1);
    check_output("first_strobe", 32'(shift_en), 32'd1);
    apply_stimulus((W - 1) * T);
    check_output("leds_full", 32'(dut_leds), 32'h0000_00FF);
    apply_stimulus((W + H) * T);
    check_output("leds_empty", 32'(dut_leds), 32'h0000_0000);

    // Direction switch flipped mid-fill takes effect only at the next fill.
    run = 1'b0;
    apply_stimulus(1);
    dir_sw = 1'b0; run = 1'b1;
    apply_stimulus(1 + 3 * T);
    check_output("leds_fill3", 32'(dut_leds), 32'h0000_0007);
    dir_sw = 1'b1;
    apply_stimulus((W - 3) * T);
    check_output("leds_full_l2r", 32'(dut_leds), 32'h0000_00FF);
    apply_stimulus((W + H) * T);
    check_output("leds_empty_l2r", 32'(dut_leds), 32'h0000_0000);
    check_output("lr_drain", 32'(lr), 32'd0);
    apply_stimulus((H + 1) * T);
    check_output("leds_r2l_1", 32'(dut_leds), 32'h0000_0080);
    check_output("lr_refill", 32'(lr), 32'd1);
    apply_stimulus(T);
    check_output("leds_r2l_2", 32'(dut_leds), 32'h0000_00C0);

    // Asynchronous reset mid-fill clears outputs without a clock edge.
    #1 reset = 1'b1;
    #1;
    check_output("rst_phase", 32'(phase), 32'd0);
    check_output("rst_s_in", 32'(s_in), 32'd0);
    check_output("rst_lr", 32'(lr), 32'd0);
    check_output("rst_shift_en", 32'(shift_en), 32'd0);
    check_output("rst_step_cnt", 32'(step_cnt), 32'd0);
    run = 1'b0;
    apply_stimulus(1);
    reset = 1'b0;
    dut_leds = 8'h00;

    // Dropping run freezes the pattern; reasserting restarts the fill.
    dir_sw = 1'b0; run = 1'b1;
    apply_stimulus(1 + 5 * T);
    check_output("leds_run_drop", 32'(dut_leds), 32'h0000_001F);
    run = 1'b0;
    apply_stimulus(3 * T);
    check_output("leds_frozen", 32'(dut_leds), 32'h0000_001F);
    check_output("idle_phase", 32'(phase), 32'd0);
    run = 1'b1;
    apply_stimulus(1);
    check_output("restart_phase", 32'(phase), 32'd1);
    check_output("restart_step", 32'(step_cnt), 32'd0);

    // Strobe spacing over three full periods.
    strobes = 0; prev_cyc = 0; prev_en = 1'b0;
    for (int cyc = 1; cyc <= 3 * SEGS * T; cyc++) begin
      apply_stimulus(1);
      check_output("adjacent", 32'(shift_en & prev_en), 32'd0);
      if (shift_en === 1'b1) begin
        if (strobes > 0)
          check_output("interval", 32'(cyc - prev_cyc), 32'((strobes % W == 0) ? (H + 1) * T : T));
        strobes++;
        prev_cyc = cyc;
      end
      prev_en = shift_en;
    end
    check_output("strobe_count", 32'(strobes), 32'(3 * 2 * W));

    // Randomised run and direction activity against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) dir_sw = ~dir_sw;
      if ($urandom_range(59) == 0) run = ~run;
      apply_stimulus(1);
    end

    check_output("hold_cycles", 32'(obs_hold_cycles), 32'(m_hold_cycles));
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/led_fill_seq.md
# led_fill_seq

Step sequencer that drives the 8-bit serial-in/parallel-out LED shifter: generates the serial bit `s_in`, direction select `lr` and a one-cycle `shift_en` strobe so the LED bar fills one LED per step and then empties one LED per step, repeating. Sits directly upstream of the shifter. The shifter's `lr=1` shifts toward LSB with `s_in` entering at MSB; `lr=0` shifts toward MSB with `s_in` entering at LSB. This block owns all effect timing; the shifter only shifts when `shift_en` is high.

## Interface
- `TICK_DIV`, default 25_000_000: clk cycles per step; legal range is ≥2.
- `WIDTH`, default 8: number of LEDs, which is also the shifts per phase; legal range is ≥2.
- `HOLD_STEPS`, default 4: idle steps at full and empty; only used with `LED_FX_HOLD_EN`.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: effect enable, level-sensitive.
- `dir_sw` in 1: direction switch. 1 means right-to-left fill (`lr=1`); 0 means left-to-right fill (`lr=0`).
- `s_in` out 1: serial bit to the shifter.
- `lr` out 1: shift direction to the shifter.
- `shift_en` out 1: one-cycle shift strobe.
- `phase` out 2: state code. IDLE=0, FILL=1, DRAIN=2, HOLD=3.
- `step_cnt` out $clog2(WIDTH+1): shifts done in the current phase.

## Operation
- Reset values:
  - FSM = IDLE, prescaler = 0, `step_cnt` = 0.
  - `s_in` = 0, `lr` = 0, `shift_en` = 0, `phase` = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while the FSM is not IDLE.
  - Wraps to 0 and raises internal `tick` for one cycle at TICK_DIV-1.
  - Held at 0 in IDLE.
- IDLE:
  - No strobes; `s_in` = 0.
  - When `run`=1: go to FILL, latch `lr` ← `dir_sw`, `step_cnt` ← 0.
- FILL:
  - `s_in` = 1.
  - On each tick: `shift_en` pulse and `step_cnt`++.
  - When `step_cnt` reaches WIDTH: `step_cnt` ← 0 and go to DRAIN (HOLD first if the macro is defined).
- DRAIN:
  - `s_in` = 0.
  - On each tick: `shift_en` pulse and `step_cnt`++.
  - When `step_cnt` reaches WIDTH: `step_cnt` ← 0, re-latch `lr` ← `dir_sw`, and go to FILL (HOLD first if the macro is defined).
- `dir_sw` is sampled only at FILL entry. A change mid-fill or mid-drain takes effect at the next FILL. `lr` is constant for a full fill/drain pair.
- `run`=0 in any state:
  - Go to IDLE on the next edge.
  - Prescaler and `step_cnt` are cleared; no further strobes.
  - The shifter keeps its current pattern; this block does not force a drain.
- `run` reasserted from IDLE always restarts at FILL with `step_cnt`=0.
- `reset` mid-sequence forces the reset values immediately, independent of clk.

## Timing
- All outputs are registered. `s_in` and `lr` are stable during every cycle where `shift_en`=1 and for at least one cycle before it.
- First `shift_en` is TICK_DIV cycles after the edge that enters FILL. After that, strobes are exactly TICK_DIV cycles apart, including across FILL↔DRAIN boundaries.
- No two consecutive cycles both have `shift_en`=1.
- `s_in` switches on the same edge as the phase change, so it is already valid TICK_DIV-1 cycles before the next strobe.
- Full period is 2·WIDTH ticks, or 2·(WIDTH+HOLD_STEPS) ticks with hold enabled.

## Configuration
- `LED_FX_HOLD_EN`:
  - **Defined:** after the WIDTH-th FILL strobe, the FSM enters HOLD for HOLD_STEPS ticks with no strobes, then goes to DRAIN. After the WIDTH-th DRAIN strobe, it holds again, then goes to FILL. `phase` = 3 during HOLD, and `step_cnt` counts hold ticks. `s_in` keeps the value of the preceding phase.
  - **Undefined:** HOLD is unreachable, `phase` never equals 3, and `HOLD_STEPS` is ignored.

## Structure
- Shared package `led_fx_pkg` holds:
  - the state enum (IDLE, FILL, DRAIN, HOLD with codes 0..3);
  - the `lr` direction constants `DIR_R2L`=1 and `DIR_L2R`=0;
  - default `TICK_DIV` and `WIDTH` values shared with the shifter top level.
- One sub-module is natural: `led_tick_gen`, a parameterised prescaler with `clk`, `reset` and `en` inputs and a one-cycle `tick` output. It is reused by other effects.

## Test plan
All scenarios use TICK_DIV=4, WIDTH=8.
- **Reset:** assert `reset` asynchronously mid-FILL → all outputs are 0 immediately and `phase`=0 before the next edge.
- **Basic fill/drain:** `run`=1, `dir_sw`=1 → 8 strobes with `s_in`=1 and `lr`=1, 4 cycles apart, then 8 strobes with `s_in`=0. A model shifter reads FF after fill and 00 after drain. The first strobe is 4 cycles after FILL entry.
- **Direction change mid-phase:** flip `dir_sw` 0→1 after the 3rd FILL strobe → `lr` stays 0 through the whole drain and becomes 1 at the next FILL entry. The model shifter fill pattern sequence is 01, 03, …, FF, then 80, C0, ….
- **Run drop:** deassert `run` after the 5th FILL strobe → no strobe afterwards, `phase`=0, and the model shifter holds 1F. Reassert `run` → FILL restarts with `step_cnt`=0.
- **Strobe spacing:** over 3 full periods, count strobes and intervals → exactly 48 strobes, every interval 4 cycles, never two adjacent cycles high.
- **Hold feature:** with `LED_FX_HOLD_EN` and HOLD_STEPS=2 → 2 strobe-free ticks with `phase`=3 after fill and after drain, giving a 20-tick period. Without the macro, `phase`=3 never occurs.
